// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). Requests are address + valid with a grant;
// responses return in order with a read-valid strobe.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order fetches, buffers
// returning words in a small queue and presents the head to decode. A flush
// redirects to the branch target and drops every older fetch, including
// responses still in flight (counted off in drop_cnt).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 flush,
    input  logic [31:0]          br_target,
    input  logic                 stall,
    output logic                 inst_valid,
    output logic [31:0]          inst,
    output logic [31:0]          inst_pc
);

    localparam int          AW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW  = $clog2(QDEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     q_inst [QDEPTH];
    logic [31:0]     q_pc   [QDEPTH];

    logic [CW:0]     credit;
    logic            req;
    logic            accept;
    logic            rsp_ok;
    logic            push;
    logic            pop;

    // Queue entries plus in-flight fetches may never exceed the queue size,
    // so every response is guaranteed a slot and push is never refused.
    assign credit = {1'b0, cnt_q} + {1'b0, out_q};
    assign req    = (state_q == S_FETCH) && !flush && (credit < (CW+1)'(QDEPTH));
    assign accept = req && imem.imem_gnt;
    assign rsp_ok = imem.imem_rvalid && (out_q != '0);
    assign push   = rsp_ok && !flush && (drop_cnt_q == '0);
    assign pop    = (cnt_q != '0) && !stall && !flush;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign inst_valid = (cnt_q != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr_q] : NOP;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr_q]   : 32'h0;

    // Next-state of PC, response PC, queue pointers and the credit counters;
    // flush overrides everything else and only in-flight fetches survive it.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (flush) begin
            pc_d       = br_target;
            rsp_pc_d   = br_target;
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // req is masked by flush, so no grant can land in this cycle.
            out_d      = out_q - CW'(rsp_ok);
            drop_cnt_d = out_q - CW'(rsp_ok);
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            out_d = out_q + CW'(accept) - CW'(rsp_ok);
            if (rsp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1'b1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control FSM: boot for one cycle, then fetch; drain stale responses after a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else if (flush) begin
            state_q <= (drop_cnt_d != '0) ? S_DRAIN : S_FETCH;
        end else begin
            case (state_q)
                S_BOOT:  state_q <= S_FETCH;
                S_FETCH: state_q <= S_FETCH;
                S_DRAIN: state_q <= (drop_cnt_d == '0) ? S_FETCH : S_DRAIN;
                default: state_q <= S_BOOT;
            endcase
        end
    end

    // Control registers: PCs, occupancy, outstanding and drop counters, pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful below cnt_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr_q] <= imem.imem_rdata;
            q_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule
